// File: rtl/dualrail_pkg.sv
// ----------------------------------------------------------------------------
// dualrail_pkg
// Shared definitions for the dual-rail bit sender:
//   - state encodings and the drs_state_t FSM enum
//   - rail_encode(): maps a data bit onto the {bit1, bit0} rail pair
// ----------------------------------------------------------------------------
package dualrail_pkg;

    localparam logic [2:0] ENC_FLUSH     = 3'd0;
    localparam logic [2:0] ENC_IDLE      = 3'd1;
    localparam logic [2:0] ENC_SET       = 3'd2;
    localparam logic [2:0] ENC_WAIT_ACK  = 3'd3;
    localparam logic [2:0] ENC_RTZ       = 3'd4;
    localparam logic [2:0] ENC_WAIT_NULL = 3'd5;
    localparam logic [2:0] ENC_DONE      = 3'd6;

    localparam logic [1:0] RAILS_NULL = 2'b00;

    typedef enum logic [2:0] {
        ST_FLUSH     = ENC_FLUSH,
        ST_IDLE      = ENC_IDLE,
        ST_SET       = ENC_SET,
        ST_WAIT_ACK  = ENC_WAIT_ACK,
        ST_RTZ       = ENC_RTZ,
        ST_WAIT_NULL = ENC_WAIT_NULL,
        ST_DONE      = ENC_DONE
    } drs_state_t;

    // A data bit is carried on exactly one rail: bit1 for a 1, bit0 for a 0.
    function automatic logic [1:0] rail_encode(input logic b);
        return {b, ~b};
    endfunction

endpackage

// File: rtl/dualrail_sync.sv
// ----------------------------------------------------------------------------
// dualrail_sync
// STAGES-deep flop chain bringing one asynchronous acknowledge rail into the
// clk domain. Resets to 0.
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high reset
//   async_in in  asynchronous input
//   sync_out out synchronised copy, STAGES cycles behind
// ----------------------------------------------------------------------------
module dualrail_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift the raw input in at the bottom of the chain each cycle.
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], async_in};
    end

    // Chain register.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/dualrail_bit_sender.sv
// ----------------------------------------------------------------------------
// dualrail_bit_sender
// Serialises a WIDTH-bit word LSB first as four-phase return-to-zero dual-rail
// transactions towards an even-zeroes stage, and reports which parity rail
// acknowledged each bit.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     word handshake, in_data sent LSB first
//   bit0, bit1            registered dual-rail data rails
//   parity0, parity1      asynchronous acknowledge rails
//   res_valid/res_ready   result handshake
//   res_trace             bit i = 1 when bit i was acknowledged on parity1
//   res_par1              acknowledging rail of the final bit
//   err                   sticky fault flag (illegal code or watchdog)
// Optional build macro: DRS_TIMEOUT_EN adds a per-phase watchdog of
// TIMEOUT_CYCLES cycles in WAIT_ACK and WAIT_NULL.
// ----------------------------------------------------------------------------
module dualrail_bit_sender
    import dualrail_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             bit0,
    output logic             bit1,
    input  logic             parity0,
    input  logic             parity1,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_trace,
    output logic             res_par1,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    drs_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] trace_q, trace_d;
    logic             par1_q, par1_d;
    logic             err_q, err_d;
    logic             bit0_q, bit0_d;
    logic             bit1_q, bit1_d;
    logic [31:0]      settle_q, settle_d;
    logic             ps0, ps1;
    logic             timeout;

    dualrail_sync #(.STAGES(SYNC_STAGES)) u_sync0 (
        .clk      (clk),
        .rst      (rst),
        .async_in (parity0),
        .sync_out (ps0)
    );

    dualrail_sync #(.STAGES(SYNC_STAGES)) u_sync1 (
        .clk      (clk),
        .rst      (rst),
        .async_in (parity1),
        .sync_out (ps1)
    );

`ifdef DRS_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    // Phase counter: counts only while the FSM stays in a wait state and
    // restarts from zero whenever the state changes.
    always_comb begin
        tmo_d = '0;
        if ((state_d == state_q) &&
            ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_NULL))) begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout = ((state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_NULL)) &&
                     (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Next-state and datapath. FLUSH first lets the synchroniser chain refill
    // (it resets to 0, which would otherwise look like a null phase while the
    // downstream stage may still be holding an acknowledge), then waits for
    // a genuine null before offering ready.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        trace_d  = trace_q;
        par1_d   = par1_q;
        err_d    = err_q;
        bit0_d   = bit0_q;
        bit1_d   = bit1_q;
        settle_d = settle_q;

        case (state_q)
            ST_FLUSH: begin
                {bit1_d, bit0_d} = RAILS_NULL;
                if (settle_q < 32'(SYNC_STAGES)) begin
                    settle_d = settle_q + 32'd1;
                end else if (!ps0 && !ps1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (in_valid) begin
                    shift_d = in_data;
                    idx_d   = '0;
                    trace_d = '0;
                    par1_d  = 1'b0;
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                {bit1_d, bit0_d} = rail_encode(shift_q[0]);
                state_d          = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (ps0 && ps1) begin
                    err_d            = 1'b1;
                    {bit1_d, bit0_d} = RAILS_NULL;
                    settle_d         = '0;
                    state_d          = ST_FLUSH;
                end else if (ps0 ^ ps1) begin
                    trace_d[idx_q] = ps1;
                    par1_d         = ps1;
                    state_d        = ST_RTZ;
                end else if (timeout) begin
                    err_d            = 1'b1;
                    {bit1_d, bit0_d} = RAILS_NULL;
                    settle_d         = '0;
                    state_d          = ST_FLUSH;
                end
            end
            ST_RTZ: begin
                {bit1_d, bit0_d} = RAILS_NULL;
                state_d          = ST_WAIT_NULL;
            end
            ST_WAIT_NULL: begin
                if (!ps0 && !ps1) begin
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                        state_d = ST_SET;
                    end
                end else if (timeout) begin
                    err_d    = 1'b1;
                    settle_d = '0;
                    state_d  = ST_FLUSH;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                {bit1_d, bit0_d} = RAILS_NULL;
                settle_d         = '0;
                state_d          = ST_FLUSH;
            end
        endcase
    end

    // State and datapath registers; reset drops the rails at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FLUSH;
            shift_q  <= '0;
            idx_q    <= '0;
            trace_q  <= '0;
            par1_q   <= 1'b0;
            err_q    <= 1'b0;
            bit0_q   <= 1'b0;
            bit1_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            trace_q  <= trace_d;
            par1_q   <= par1_d;
            err_q    <= err_d;
            bit0_q   <= bit0_d;
            bit1_q   <= bit1_d;
            settle_q <= settle_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    assign res_trace = trace_q;
    assign res_par1  = par1_q;
    assign err       = err_q;
    assign bit0      = bit0_q;
    assign bit1      = bit1_q;

endmodule

// File: tb/tb_dualrail_bit_sender.sv
// ----------------------------------------------------------------------------
// tb_dualrail_bit_sender
// Drives dualrail_bit_sender (WIDTH=4, SYNC_STAGES=2) against a behavioural
// even-zeroes stage: it acknowledges 3 cycles after a rail rises (parity1 when
// the running zero count of the word is odd, parity0 when even) and releases
// 3 cycles after the rails return to null. Directed scenarios come first,
// then randomized words checked against an arithmetic trace model.
// Build with DRS_TIMEOUT_EN to add the watchdog scenario.
// ----------------------------------------------------------------------------
module tb_dualrail_bit_sender;

    localparam int W = 4;
    localparam int S = 2;
`ifdef DRS_TIMEOUT_EN
    localparam int TMO = 15;
`else
    localparam int TMO = 1023;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         bit0;
    logic         bit1;
    logic         parity0 = 1'b0;
    logic         parity1 = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_trace;
    logic         res_par1;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Environment controls: 0 normal, 1 illegal code on bit 2, 2 silent.
    int   env_mode = 0;
    logic env_new_word = 1'b0;
    logic env_acked = 1'b0;
    int   env_dly = 0;
    int   env_zeros = 0;
    int   env_bitno = 0;

    logic rail_q[$];
    logic prev_rails = 1'b0;
    logic saw_res_valid = 1'b0;

    dualrail_bit_sender #(
        .WIDTH          (W),
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bit0      (bit0),
        .bit1      (bit1),
        .parity0   (parity0),
        .parity1   (parity1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_trace (res_trace),
        .res_par1  (res_par1),
        .err       (err)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: acknowledge rail of each bit from the running zero count.
    function automatic logic [W-1:0] expTrace(input logic [W-1:0] d);
        logic [W-1:0] t;
        int zeros;
        t     = '0;
        zeros = 0;
        for (int i = 0; i < W; i++) begin
            if (d[i] == 1'b0) zeros++;
            t[i] = (zeros % 2 == 1);
        end
        return t;
    endfunction

    // Even-zeroes stage model, acting 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (env_new_word) begin
            env_zeros    = 0;
            env_bitno    = 0;
            env_new_word = 1'b0;
        end
        if ((bit0 || bit1) && !env_acked) begin
            env_dly++;
            if (env_dly >= 3 && env_mode != 2) begin
                if (env_mode == 1 && env_bitno == 2) begin
                    parity0 = 1'b1;
                    parity1 = 1'b1;
                end else begin
                    if (bit0) env_zeros++;
                    parity1 = (env_zeros % 2 == 1);
                    parity0 = !parity1;
                end
                env_acked = 1'b1;
                env_dly   = 0;
            end
        end else if (!(bit0 || bit1) && env_acked) begin
            env_dly++;
            if (env_dly >= 3) begin
                parity0   = 1'b0;
                parity1   = 1'b0;
                env_acked = 1'b0;
                env_dly   = 0;
                env_bitno++;
            end
        end else begin
            env_dly = 0;
        end
    end

    // Rail monitor: one-hot invariant, rail order capture, stray results.
    always @(negedge clk) begin
        checkOutput("rails_one_hot", {31'd0, bit0 & bit1}, 32'd0);
        if ((bit0 || bit1) && !prev_rails) rail_q.push_back(bit1);
        prev_rails = bit0 || bit1;
        if (res_valid) saw_res_valid = 1'b1;
    end

    // Offer one word once the block is ready.
    task automatic applyStimulus(input logic [W-1:0] data);
        for (int n = 0; n < 200 && !in_ready; n++) @(negedge clk);
        checkOutput("in_ready_wait", {31'd0, in_ready}, 32'd1);
        rail_q.delete();
        in_data      = data;
        in_valid     = 1'b1;
        env_new_word = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full word: send, check result and rails, hold off the consumer.
    task automatic runWord(input logic [W-1:0] data, input int stall);
        logic [W-1:0] exp_t;
        logic [W-1:0] seq;
        exp_t = expTrace(data);
        applyStimulus(data);
        for (int n = 0; n < 1000 && !res_valid; n++) @(negedge clk);
        checkOutput("res_valid_wait", {31'd0, res_valid}, 32'd1);
        checkOutput("res_trace", 32'(res_trace), 32'(exp_t));
        checkOutput("res_par1", {31'd0, res_par1}, {31'd0, exp_t[W-1]});
        checkOutput("err_clean", {31'd0, err}, 32'd0);
        seq = '0;
        for (int i = 0; i < rail_q.size() && i < W; i++) seq[i] = rail_q[i];
        checkOutput("rail_count", 32'(rail_q.size()), 32'(W));
        checkOutput("rail_seq", 32'(seq), 32'(data));
        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            checkOutput("stall_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("stall_trace", 32'(res_trace), 32'(exp_t));
            checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checkOutput("release_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("release_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] global timeout");
    end

    // Directed scenarios followed by randomized words.
    initial begin
        int csf;
        logic [W-1:0] rdata;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_bit0", {31'd0, bit0}, 32'd0);
        checkOutput("rst_bit1", {31'd0, bit1}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_res_trace", 32'(res_trace), 32'd0);
        checkOutput("rst_res_par1", {31'd0, res_par1}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        // Directed words, the second one with a long consumer stall.
        runWord(4'b0100, 2);
        checkOutput("dir_0100_trace", 32'(res_trace), 32'h9);
        runWord(4'b1111, 20);
        checkOutput("dir_1111_trace", 32'(res_trace), 32'h0);

        // Illegal code on bit 2.
        env_mode      = 1;
        saw_res_valid = 1'b0;
        applyStimulus(4'b1010);
        for (int n = 0; n < 500 && !err; n++) @(negedge clk);
        checkOutput("illegal_err", {31'd0, err}, 32'd1);
        checkOutput("illegal_rails", {30'd0, bit1, bit0}, 32'd0);
        for (int n = 0; n < 500 && !in_ready; n++) @(negedge clk);
        checkOutput("illegal_recover", {31'd0, in_ready}, 32'd1);
        checkOutput("illegal_no_result", {31'd0, saw_res_valid}, 32'd0);
        checkOutput("illegal_err_sticky", {31'd0, err}, 32'd1);
        env_mode = 0;

        // Reset while bit1 and parity1 are high.
        applyStimulus(4'b0010);
        for (int n = 0; n < 500 && !(bit1 && parity1); n++) @(negedge clk);
        checkOutput("rstmid_bit1_high", {31'd0, bit1 & parity1}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rstmid_rails", {30'd0, bit1, bit0}, 32'd0);
        checkOutput("rstmid_err_cleared", {31'd0, err}, 32'd0);
        csf = 0;
        for (int n = 0; n < 60 && !in_ready; n++) begin
            if (parity1) csf = 0;
            else csf++;
            if (parity1 || csf <= S)
                checkOutput("rstmid_hold_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        checkOutput("rstmid_ready", {31'd0, in_ready}, 32'd1);

        // Randomized words.
        for (int k = 0; k < 12; k++) begin
            rdata = W'($urandom_range(0, (1 << W) - 1));
            runWord(rdata, int'($urandom_range(0, 5)));
        end

`ifdef DRS_TIMEOUT_EN
        // Silent stage: watchdog fires TMO cycles after WAIT_ACK entry.
        env_mode = 2;
        applyStimulus(W'($urandom_range(0, (1 << W) - 1)));
        for (int n = 0; n < 100 && !(bit0 || bit1); n++) @(negedge clk);
        checkOutput("tmo_rail_up", {31'd0, bit0 | bit1}, 32'd1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk);
            checkOutput("tmo_err", {31'd0, err}, (k < TMO) ? 32'd0 : 32'd1);
        end
        checkOutput("tmo_rails", {30'd0, bit1, bit0}, 32'd0);
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        checkOutput("tmo_ready", {31'd0, in_ready}, 32'd1);
        env_mode = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dualrail_bit_sender.md
Name: dualrail_bit_sender

Overview:
- Clocked producer-side driver for the even-zeroes dual-rail stage. Sits directly upstream of it and drives its bit0/bit1 inputs.
- Takes a WIDTH-bit word over a valid/ready interface and serialises it LSB first.
- Each bit is sent as one four-phase return-to-zero dual-rail transaction: raise rail, wait for parity0|parity1, lower rail, wait for both parity rails low.
- Records which parity rail acknowledged each bit and returns the trace on a clocked result interface.

Parameters:
- WIDTH, 8: data bits per word; legal range 1..32.
- SYNC_STAGES, 2: flop stages on each asynchronous parity input; minimum 2.
- TIMEOUT_CYCLES, 1023: watchdog limit per handshake phase; used only with DRS_TIMEOUT_EN.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  word offered.
- in_ready  out  1  block accepts a word.
- in_data  in  WIDTH  word, sent LSB first.
- bit0  out  1  dual-rail data rail "0", registered.
- bit1  out  1  dual-rail data rail "1", registered.
- parity0  in  1  async acknowledge rail "0" from the even-zeroes stage.
- parity1  in  1  async acknowledge rail "1".
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_trace  out  WIDTH  bit i = 1 if bit i was acknowledged on parity1, 0 if on parity0.
- res_par1  out  1  acknowledging rail of the final bit (1 = parity1).
- err  out  1  sticky fault flag.

Behaviour:
- Reset values:
  - bit0 = bit1 = 0, in_ready = 0, res_valid = 0, res_trace = 0, res_par1 = 0, err = 0.
  - State after reset is FLUSH.
- Synchroniser:
  - parity0 and parity1 each pass through SYNC_STAGES flops; ps0/ps1 are the synchronised copies.
  - All decisions use ps0/ps1 only.
- FSM states: FLUSH, IDLE, SET, WAIT_ACK, RTZ, WAIT_NULL, DONE.
- FLUSH:
  - Rails low. Go to IDLE once ps0 = ps1 = 0.
  - Guarantees a clean null phase after reset mid-transaction.
- IDLE:
  - in_ready = 1 in IDLE only.
  - On in_valid & in_ready: latch in_data into the shift register, set bit index to 0, clear the trace, go to SET.
- SET (one cycle):
  - Register bit1 = cur_bit, bit0 = ~cur_bit.
  - Exactly one rail is high from the next edge. Go to WAIT_ACK.
- WAIT_ACK:
  - Rails held.
  - ps0 ^ ps1 = 1: trace[idx] = ps1, go to RTZ.
  - ps0 & ps1 = 1: illegal code. Set err, drop rails, go to FLUSH, no result.
- RTZ (one cycle): clear both rails, go to WAIT_NULL.
- WAIT_NULL:
  - Wait for ps0 = ps1 = 0.
  - If idx = WIDTH-1, go to DONE. Otherwise idx++, shift the register right, go to SET.
- DONE:
  - res_valid = 1; res_trace and res_par1 are stable.
  - On res_ready, go to IDLE; res_valid falls at that edge.
  - The next word can be accepted no earlier than the cycle after.
- Latency per bit: 4 + 2·SYNC_STAGES cycles minimum, assuming zero environment delay.
- Word latency: WIDTH times the per-bit latency, plus 2 cycles.
- Rail invariants:
  - bit0 & bit1 is never 1.
  - Rails never change while in WAIT_ACK.
  - A new rail is never raised before the null phase is observed.
- err is sticky until rst. With err set, the FSM continues operating.
- rst while rails are high: rails drop at that edge, then FLUSH waits for the parity rails to return to null.

Optional Feature:
- DRS_TIMEOUT_EN defined:
  - A per-phase counter runs in WAIT_ACK and WAIT_NULL and is cleared on every state change.
  - On reaching TIMEOUT_CYCLES: set err, drop rails, go to FLUSH, no result.
- DRS_TIMEOUT_EN undefined: no counter logic; the FSM waits indefinitely.

Decomposition:
- Package dualrail_pkg:
  - State enum drs_state_t.
  - Localparams for state encoding.
  - Function rail_encode(bit) returning {bit1, bit0}.
- Sub-module dualrail_sync: SYNC_STAGES-deep flop chain on a 1-bit async input, reset to 0; instantiated once per parity rail.

Test Plan:
All scenarios run against a behavioural even-zeroes model that asserts parity0 if the running zero count is even, parity1 if odd. The model responds 3 cycles after a rail rises and deasserts 3 cycles after rails return to null.
- WIDTH=4, in_data=4'b0100:
  - Rails sequence bit0, bit0, bit1, bit0.
  - res_trace=4'b1001, res_par1=1, err=0.
- WIDTH=4, in_data=4'b1111:
  - Rails sequence bit1 ×4.
  - res_trace=4'b0000, res_par1=0.
- res_ready held low 20 cycles in DONE:
  - res_valid and res_trace stay stable.
  - in_ready stays 0 until the cycle after res_ready.
- Model drives parity0 = parity1 = 1 during bit 2:
  - err=1, rails low, no res_valid.
  - FSM reaches IDLE once the model releases both rails.
- rst pulsed while bit1 is high and parity1 is high:
  - Rails 0 the cycle after.
  - in_ready stays 0 until ps1 falls, then becomes 1.
- With DRS_TIMEOUT_EN and TIMEOUT_CYCLES=15, model never acknowledges:
  - err=1 exactly 15 cycles after WAIT_ACK entry.
  - Rails dropped, in_ready returns to 1.
